// File: rtl/conversor_bcd_serial.sv
// conversor_bcd_serial: 8-bit binary to 3-digit BCD converter, one double-dabble
// iteration per clock, registered digits with a one-cycle done pulse.
module conversor_bcd_serial (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [7:0] bin_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] centenas_o,
   output logic [3:0] dezenas_o,
   output logic [3:0] unidades_o
);
   typedef enum logic [1:0] {IDLE, CONV, FIM} state_t;
   state_t      state_q;
   logic [19:0] work_q, work_d;
   logic [3:0]  cnt_q;
   logic [11:0] dig_q;
   logic        busy_q, done_q;
   // add-3 on every BCD nibble >= 5, then shift the whole register left
   always_comb begin
      work_d = work_q;
      for (int n = 0; n < 3; n++)
         work_d[8+4*n +: 4] = (work_q[8+4*n +: 4] >= 4'd5) ? work_q[8+4*n +: 4] + 4'd3 : work_q[8+4*n +: 4];
      work_d = {work_d[18:0], 1'b0};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  work_q  <= {12'b0, bin_i};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CONV;
               end
            end
            CONV: begin
               work_q <= work_d;
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  dig_q   <= work_d[19:8];
                  done_q  <= 1'b1;
                  state_q <= FIM;
               end
            end
            FIM: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign centenas_o = dig_q[11:8];
   assign dezenas_o  = dig_q[7:4];
   assign unidades_o = dig_q[3:0];
endmodule

// File: tb/tb_conversor_bcd_serial.sv
// tb_conversor_bcd_serial: table, sweep and random checks of the BCD converter
// against a decimal-arithmetic reference, plus multi-cycle corner sequences.
module tb_conversor_bcd_serial;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] bin = '0;
   logic       busy, done;
   logic [3:0] cen, dez, uni;
   int         n_vec = 0;
   int         n_err = 0;

   conversor_bcd_serial dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bin),
      .busy_o(busy), .done_o(done),
      .centenas_o(cen), .dezenas_o(dez), .unidades_o(uni)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] v;
      logic [3:0] c, d, u;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_dec(input int v);
      return (v / 100) * 100 + ((v / 10) % 10) * 10 + v % 10;
   endfunction

   task automatic chk_digits(input string name, input int v);
      chk({name, " digits"}, int'(cen) * 100 + int'(dez) * 10 + int'(uni), ref_dec(v));
      chk({name, " cen"}, int'(cen), v / 100);
      chk({name, " dez"}, int'(dez), (v / 10) % 10);
      chk({name, " uni"}, int'(uni), v % 10);
   endtask

   // full transaction: capture, latency, busy width, digits, done fall
   task automatic convert(input int v, input string name);
      int lat, bcnt;
      @(negedge clk);
      start = 1'b1;
      bin   = 8'(v);
      @(negedge clk);
      start = 1'b0;
      bin   = 8'($urandom);
      lat   = 0;
      bcnt  = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      chk({name, " latency"}, lat, 8);
      chk_digits(name, v);
      @(negedge clk);
      chk({name, " busy width"}, bcnt, 9);
      chk({name, " busy fall"}, int'(busy), 0);
      chk({name, " done fall"}, int'(done), 0);
   endtask

   vec_t tbl[$];

   initial begin
      int k, last, pulses, gap;
      tbl.push_back('{8'd0, 4'd0, 4'd0, 4'd0});
      tbl.push_back('{8'd255, 4'd2, 4'd5, 4'd5});
      tbl.push_back('{8'd100, 4'd1, 4'd0, 4'd0});
      tbl.push_back('{8'd5, 4'd0, 4'd0, 4'd5});
      tbl.push_back('{8'd225, 4'd2, 4'd2, 4'd5});
      tbl.push_back('{8'd99, 4'd0, 4'd9, 4'd9});
      tbl.push_back('{8'd50, 4'd0, 4'd5, 4'd0});

      #12;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset digits", int'({cen, dez, uni}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         convert(tbl[i].v, "table");
         chk("table const", int'({cen, dez, uni}), int'({tbl[i].c, tbl[i].d, tbl[i].u}));
      end

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            convert(a * b, "sweep");

      repeat (60) convert(int'($urandom_range(0, 255)), "random");

      // start again at k+3 with a new value is ignored
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd37;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd200;
      @(negedge clk);
      start = 1'b0;
      k = 3;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("busy start latency", k, 8);
      chk_digits("busy start", 37);
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("busy start extra done", pulses, 0);
      chk("busy start idle", int'(busy), 0);
      chk_digits("busy start hold", 37);

      // reset mid-conversion clears previous result and aborts
      convert(123, "pre reset");
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd45;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort digits", int'({cen, dez, uni}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("abort no done", pulses, 0);
      convert(45, "after reset");

      // start held high: one result every 10 cycles, digits steady
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd66;
      last = -1;
      pulses = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done) begin
            if (last >= 0) begin
               gap = c - last;
               chk("held period", gap, 10);
            end
            last = c;
            pulses++;
         end
         if (pulses > 0) chk("held digits", int'(cen) * 100 + int'(dez) * 10 + int'(uni), 66);
      end
      chk("held pulses", int'(pulses >= 4), 1);
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit %0d", 2000000);
      $fatal(1);
   end
endmodule

// File: doc/conversor_bcd_serial.md
# conversor_bcd_serial

Sequential binary-to-BCD converter sitting directly downstream of the 4x4 multiplier. It captures the 8-bit product on a start pulse and converts it with the shift-and-add-3 (double dabble) algorithm, one bit per clock. It presents hundreds, tens and units digits to the 7-segment display decoders, and a one-cycle done pulse marks each new result.

## Interface
- Parameters: none. Input width is fixed at 8 bits, output at 3 BCD digits.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  8  unsigned binary value (multiplier product P), sampled on the start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a new result is loaded on the digit outputs.
- centenas  output  4  BCD hundreds digit (0..2).
- dezenas  output  4  BCD tens digit (0..9).
- unidades  output  4  BCD units digit (0..9).

## Operation
- States: IDLE, CONV, FIM.
- Internal registers:
  - 20-bit work register: bits [19:8] hold the 3 BCD digits, bits [7:0] hold the remaining binary.
  - 4-bit iteration counter.
- IDLE:
  - On start=1, load the work register with {12'b0, bin}, clear the counter, go to CONV.
  - On start=0, stay in IDLE.
- CONV, each cycle:
  - First, each of the 3 BCD nibbles with value >= 5 gets +3 added (4-bit add, no carry out of the nibble).
  - Then the whole 20-bit register shifts left by 1 with 0 shifted in.
  - The counter increments.
  - After the 8th iteration (counter reaches 7 during that cycle), go to FIM. On that same edge, load centenas/dezenas/unidades from the post-shift bits [19:8] and set done=1.
- FIM: clear done and return to IDLE unconditionally. A start seen in FIM is ignored.
- start while busy (CONV or FIM) is ignored. It is neither queued nor does it restart the conversion. bin may change freely after the capture edge.
- Digit outputs hold the last completed result until the next completion. They never show partial values.
- Value range: 0..255 converts correctly (centenas <= 2). Multiplier products never exceed 225.
- Reset (rst_n=0, any time, including mid-conversion):
  - Immediately forces state=IDLE, busy=0, done=0, and all digit outputs, work register and counter to 0.
  - An aborted conversion produces no done pulse.
  - After rst_n deasserts, the first rising edge with start=1 begins a conversion.

## Timing
- Let edge k be the rising edge on which start=1 is sampled in IDLE.
- busy rises after edge k and stays high through edge k+9.
- Edges k+1..k+8 perform the 8 iterations.
- The digit outputs update and done rises after edge k+8. done falls after edge k+9.
- Latency is 8 cycles from the capture edge to valid digits. A full transaction occupies 9 cycles, plus 1 IDLE cycle before the next capture.
- If start is held high continuously, a new capture occurs on edge k+10, giving one conversion every 10 cycles.
- All outputs are registered. There is no combinational path from start or bin to any output.
- Reset values: busy=0, done=0, centenas=0, dezenas=0, unidades=0.

## Test plan
- Reset, then bin=0, start pulse -> done pulses exactly 8 cycles after the capture edge; digits 0,0,0; busy high for exactly 9 cycles.
- Sweep bin = A*B for all A,B in 0..15, each followed by a start pulse -> digits equal the decimal of the product every time, e.g. 15*15=225 gives 2,2,5 and 9*11=99 gives 0,9,9.
- bin=255 -> 2,5,5. bin=100 -> 1,0,0. bin=5 -> 0,0,5. These cover the add-3 boundary on every nibble.
- Start at edge k with bin=37, then pulse start again at k+3 with bin changed to 200 -> one done only, digits 0,3,7; no second conversion until start is reasserted in IDLE.
- Complete a conversion of 123, then start 45 and pulse rst_n low at k+4 -> busy, done and all digits go to 0 asynchronously (the previous 1,2,3 is cleared); no done follows; next start with 45 yields 0,4,5.
- start held high with bin=66 -> done pulses every 10 cycles, digits stable at 0,6,6 and never glitch between pulses.
